// File: rtl/softmax_online_acc.sv
// Online-softmax statistics engine: per-row running max and exp2-weighted denominator,
// one element per row per beat, three pipeline stages per lane, optional tile continuation.
module softmax_online_acc #(
  parameter int ROWS  = 16,
  parameter int DW    = 16,
  parameter int FRAC  = 7,
  parameter int LEN_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_cont,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [ROWS*DW-1:0]   i_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [ROWS*DW-1:0]   o_max,
  output logic [ROWS*DW-1:0]   o_denom
);

  localparam int TW = DW + 1;  // max-difference width
  localparam int UW = DW + 3;  // difference scaled by ~log2(e), with headroom
  localparam logic signed [DW-1:0] M_INIT = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [1:0]       drain_q;
  logic             start_go, clear_md, accept, s1_v, s2_v;

  assign start_go = (state == IDLE) && i_start;
  assign clear_md = start_go && !i_cont && (i_len != '0);
  assign accept   = (state == ACC) && i_in_valid;

  // 2^(t*log2e) for t <= 0 in QFRAC: split into integer and fractional exponent,
  // use 1+f as the mantissa and shift right by the integer part.
  function automatic logic [DW-1:0] exp2_neg(input logic signed [TW-1:0] t);
    logic signed [UW-1:0] tw, u, k, nk;
    logic [FRAC-1:0]      f;
    logic [DW-1:0]        mant;
    tw   = UW'(t);
    u    = tw + (tw >>> 1) - (tw >>> 4);
    k    = u >>> FRAC;
    nk   = -k;
    f    = u[FRAC-1:0];
    mant = DW'({1'b1, f});
    if (nk >= UW'(DW)) return '0;
    return mant >> nk;
  endfunction

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    state_nx    = state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    unique case (state)
      IDLE:  if (i_start) state_nx = (i_len == '0) ? DONE : ACC;
      ACC: begin
        o_in_ready = 1'b1;
        if (i_in_valid && (cnt_q == len_q - LEN_W'(1))) state_nx = DRAIN;
      end
      DRAIN: if (drain_q == 2'd2) state_nx = DONE;
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_nx = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_go) begin
        len_q <= i_len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      drain_q <= (state == DRAIN) ? drain_q + 2'd1 : 2'd0;
      s1_v    <= accept;
      s2_v    <= s1_v;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic signed [DW-1:0] x, m_q, m_new;
    logic [DW-1:0]        d_q, ea_q, eb_q, d_next;
    logic signed [TW-1:0] a_q, b_q;
    logic [2*DW-1:0]      prod;
    logic [2*DW:0]        sum;

    assign x      = i_data[r*DW +: DW];
    assign m_new  = (x > m_q) ? x : m_q;
    assign prod   = (2*DW)'(d_q) * (2*DW)'(ea_q);
    assign sum    = (2*DW+1)'(prod >> FRAC) + (2*DW+1)'(eb_q);
    assign d_next = (|sum[2*DW:DW]) ? '1 : sum[DW-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        m_q <= M_INIT;
        d_q <= '0;
      end else if (clear_md) begin
        m_q <= M_INIT;
        d_q <= '0;
      end else begin
        if (accept) m_q <= m_new;
        if (s2_v)   d_q <= d_next;
      end
    end

    // NOTE: pipeline data registers carry no reset; s1_v/s2_v gate every use of them.
    always_ff @(posedge i_clk) begin
      if (accept) begin
        a_q <= TW'(m_q) - TW'(m_new);
        b_q <= TW'(x) - TW'(m_new);
      end
      if (s1_v) begin
        ea_q <= exp2_neg(a_q);
        eb_q <= exp2_neg(b_q);
      end
    end

    assign o_max[r*DW +: DW]   = m_q;
    assign o_denom[r*DW +: DW] = d_q;
  end

endmodule
